// File: rtl/mode_0.sv
// mode_0 : SPI Mode 0 (CPOL=0, CPHA=0) master for single 8-bit full-duplex
// transfers. A local controller pulses start with a byte; the byte is shifted
// out MSB-first on mosi while miso is shifted in, and the received byte is
// presented on data_out when the transfer completes.
//
// Parameters:
//   CLK_DIV   system clocks per SCLK half-period (>= 1)
//
// Ports:
//   clk       system clock, all logic on rising edge
//   rst       asynchronous active-low reset
//   start     single-cycle transfer request, honoured only when idle
//   data_in   byte to transmit, captured with an accepted start
//   miso      serial data from the slave
//   sclk      SPI clock, idles low
//   mosi      serial data to the slave
//   ss        active-low slave select
//   data_out  last completely received byte
//   busy      high while a transfer is in progress

module mode_0 #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       ss,
  output logic [7:0] data_out,
  output logic       busy
);

  // A divide of 1 still needs a one-bit counter so the wrap compare stays legal.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       edge_cnt;
  logic [6:0]       tx_shift;
  logic [7:0]       rx_shift;
  logic [4:0]       next_edge;

  // Number of the half-period event that fires on the current divider wrap.
  assign next_edge = edge_cnt + 5'd1;

  // The MSB goes straight onto mosi at start, so tx_shift only has to hold
  // the remaining seven bits. Odd events raise sclk and sample miso; even
  // events lower sclk and advance mosi, except the 16th, which closes the
  // transfer and publishes the received byte in the same clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss       <= 1'b1;
      busy     <= 1'b0;
      data_out <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          sclk <= 1'b0;
          ss   <= 1'b1;
          busy <= 1'b0;
          mosi <= 1'b0;
          if (start) begin
            tx_shift <= data_in[6:0];
            mosi     <= data_in[7];
            ss       <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            edge_cnt <= '0;
            state    <= XFER;
          end
        end

        XFER: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            edge_cnt <= next_edge;
            if (next_edge[0]) begin
              sclk     <= 1'b1;
              rx_shift <= {rx_shift[6:0], miso};
            end else if (next_edge == 5'd16) begin
              sclk     <= 1'b0;
              data_out <= rx_shift;
              ss       <= 1'b1;
              busy     <= 1'b0;
              mosi     <= 1'b0;
              state    <= IDLE;
            end else begin
              sclk     <= 1'b0;
              mosi     <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mode_0.sv
// tb_mode_0 : directed testbench for the mode_0 SPI master. One instance runs
// at the default divide of 4, a second at a divide of 1. Each instance talks
// to a small behavioural slave that puts its MSB on miso when ss falls and
// advances one bit on every falling sclk. Outputs are sampled on the falling
// clk edge, half a period away from the active edge.
//
// Ports: none (top-level bench).

module tb_mode_0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start1;
  logic [7:0] data_in, data_in1;
  logic       miso, miso1;
  logic       sclk, mosi, ss, busy;
  logic       sclk1, mosi1, ss1, busy1;
  logic [7:0] data_out, data_out1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mode_0 dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .miso(miso),
    .sclk(sclk), .mosi(mosi), .ss(ss), .data_out(data_out), .busy(busy)
  );

  mode_0 #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in1), .miso(miso1),
    .sclk(sclk1), .mosi(mosi1), .ss(ss1), .data_out(data_out1), .busy(busy1)
  );

  // Behavioural slaves: bit index = falling sclk edges since ss fell.
  logic [7:0] slave_tx, slave_tx1;
  int fall_cnt = 0, fall_base = 0, fall_cnt1 = 0, fall_base1 = 0;
  int slave_idx, slave_idx1;
  logic [2:0] bit_sel, bit_sel1;

  always @(negedge sclk)  fall_cnt   <= fall_cnt + 1;
  always @(negedge ss)    fall_base  <= fall_cnt;
  always @(negedge sclk1) fall_cnt1  <= fall_cnt1 + 1;
  always @(negedge ss1)   fall_base1 <= fall_cnt1;

  assign slave_idx  = fall_cnt - fall_base;
  assign slave_idx1 = fall_cnt1 - fall_base1;
  assign bit_sel    = 3'(7 - slave_idx);
  assign bit_sel1   = 3'(7 - slave_idx1);
  assign miso  = (slave_idx  >= 0 && slave_idx  < 8) ? slave_tx[bit_sel]   : 1'b0;
  assign miso1 = (slave_idx1 >= 0 && slave_idx1 < 8) ? slave_tx1[bit_sel1] : 1'b0;

  // Record mosi at every rising sclk; the last eight bits form the sent byte.
  logic [7:0] mosi_cap = 8'h00, mosi_cap1 = 8'h00;
  int rise_cnt = 0, rise_cnt1 = 0;

  always @(posedge sclk) begin
    mosi_cap <= {mosi_cap[6:0], mosi};
    rise_cnt <= rise_cnt + 1;
  end

  always @(posedge sclk1) begin
    mosi_cap1 <= {mosi_cap1[6:0], mosi1};
    rise_cnt1 <= rise_cnt1 + 1;
  end

  // Request one transfer; returns on the first sample with busy high.
  task automatic start_xfer(input bit fast, input logic [7:0] d, input logic [7:0] s);
    @(negedge clk);
    if (fast) begin
      data_in1 = d; slave_tx1 = s; start1 = 1'b1;
    end else begin
      data_in = d; slave_tx = s; start = 1'b1;
    end
    @(negedge clk);
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  // Walk the busy window one sample per clk. Counts busy samples, samples
  // where sclk deviates from the ideal waveform for the divide, and samples
  // with ss not low. Optionally pulses start (data 8'h55) at sample inject.
  task automatic measure(input bit fast, input int inject, output int bcnt,
                         output int sclk_err, output int ss_err, output bit tmo);
    int div;
    logic b, sc, s;
    div = fast ? 1 : 4;
    bcnt = 0; sclk_err = 0; ss_err = 0; tmo = 1'b0;
    forever begin
      b  = fast ? busy1 : busy;
      sc = fast ? sclk1 : sclk;
      s  = fast ? ss1   : ss;
      if (!b) break;
      bcnt++;
      if (sc !== ((((bcnt - 1) / div) % 2) == 1)) sclk_err++;
      if (s !== 1'b0) ss_err++;
      if (bcnt == inject) begin
        start = 1'b1; data_in = 8'h55;
      end else if (bcnt == inject + 1) begin
        start = 1'b0;
      end
      if (bcnt > 200) begin
        tmo = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; start1 = 1'b0;
    data_in = 8'h00; data_in1 = 8'h00; slave_tx = 8'h00; slave_tx1 = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (sclk !== 1'b0) begin fails++; $display("[TB] FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (mosi !== 1'b0) begin fails++; $display("[TB] FAIL reset_mosi: got %b expected 0", mosi); end
    checks++; if (ss !== 1'b1) begin fails++; $display("[TB] FAIL reset_ss: got %b expected 1", ss); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (data_out !== 8'h00) begin fails++; $display("[TB] FAIL reset_data_out: got %h expected 00", data_out); end
    checks++; if (ss1 !== 1'b1 || busy1 !== 1'b0) begin fails++; $display("[TB] FAIL reset_fast_ss_busy: got %b%b expected 10", ss1, busy1); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || sclk !== 1'b0) begin fails++; $display("[TB] FAIL idle_after_reset: got busy=%b sclk=%b expected 0 0", busy, sclk); end
  endtask

  task automatic test_basic();
    int bc, se, sse, r0;
    bit tmo;
    r0 = rise_cnt;
    start_xfer(1'b0, 8'hAA, 8'hCC);
    measure(1'b0, -1, bc, se, sse, tmo);
    checks++; if (tmo !== 1'b0) begin fails++; $display("[TB] FAIL basic_timeout: busy never fell"); end
    checks++; if (bc != 64) begin fails++; $display("[TB] FAIL basic_busy_len: got %0d expected 64", bc); end
    checks++; if (se != 0) begin fails++; $display("[TB] FAIL basic_sclk_wave: got %0d bad samples expected 0", se); end
    checks++; if (sse != 0) begin fails++; $display("[TB] FAIL basic_ss_window: got %0d bad samples expected 0", sse); end
    checks++; if (rise_cnt - r0 != 8) begin fails++; $display("[TB] FAIL basic_rise_count: got %0d expected 8", rise_cnt - r0); end
    checks++; if (mosi_cap !== 8'hAA) begin fails++; $display("[TB] FAIL basic_mosi: got %h expected aa", mosi_cap); end
    checks++; if (data_out !== 8'hCC) begin fails++; $display("[TB] FAIL basic_data_out: got %h expected cc", data_out); end
    checks++; if (ss !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin fails++; $display("[TB] FAIL basic_end_idle: got ss=%b sclk=%b mosi=%b expected 1 0 0", ss, sclk, mosi); end
  endtask

  task automatic test_ignore_start();
    int bc, se, sse, seen;
    bit tmo;
    start_xfer(1'b0, 8'hAA, 8'hCC);
    measure(1'b0, 20, bc, se, sse, tmo);
    checks++; if (tmo !== 1'b0 || bc != 64) begin fails++; $display("[TB] FAIL ignore_busy_len: got %0d expected 64", bc); end
    checks++; if (mosi_cap !== 8'hAA) begin fails++; $display("[TB] FAIL ignore_mosi: got %h expected aa", mosi_cap); end
    checks++; if (data_out !== 8'hCC) begin fails++; $display("[TB] FAIL ignore_data_out: got %h expected cc", data_out); end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) seen++;
    end
    checks++; if (seen != 0) begin fails++; $display("[TB] FAIL ignore_no_requeue: got %0d busy samples expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    int bc, se, sse;
    bit tmo;
    start_xfer(1'b0, 8'h0F, 8'hF0);
    measure(1'b0, -1, bc, se, sse, tmo);
    checks++; if (data_out !== 8'hF0) begin fails++; $display("[TB] FAIL b2b_first_data: got %h expected f0", data_out); end
    checks++; if (mosi_cap !== 8'h0F) begin fails++; $display("[TB] FAIL b2b_first_mosi: got %h expected 0f", mosi_cap); end
    checks++; if (ss !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ss_gap: got %b expected 1", ss); end
    start_xfer(1'b0, 8'h81, 8'h3C);
    measure(1'b0, -1, bc, se, sse, tmo);
    checks++; if (tmo !== 1'b0 || bc != 64) begin fails++; $display("[TB] FAIL b2b_second_len: got %0d expected 64", bc); end
    checks++; if (data_out !== 8'h3C) begin fails++; $display("[TB] FAIL b2b_second_data: got %h expected 3c", data_out); end
    checks++; if (mosi_cap !== 8'h81) begin fails++; $display("[TB] FAIL b2b_second_mosi: got %h expected 81", mosi_cap); end
  endtask

  task automatic test_held_start();
    int bc, se, sse;
    bit tmo;
    @(negedge clk);
    data_in = 8'h5A; slave_tx = 8'h96; start = 1'b1;
    @(negedge clk);
    measure(1'b0, -1, bc, se, sse, tmo);
    checks++; if (ss !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL held_gap: got ss=%b busy=%b expected 1 0", ss, busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || ss !== 1'b0) begin fails++; $display("[TB] FAIL held_restart: got busy=%b ss=%b expected 1 0", busy, ss); end
    start = 1'b0;
    measure(1'b0, -1, bc, se, sse, tmo);
    checks++; if (tmo !== 1'b0 || bc != 64) begin fails++; $display("[TB] FAIL held_second_len: got %0d expected 64", bc); end
    checks++; if (data_out !== 8'h96) begin fails++; $display("[TB] FAIL held_data: got %h expected 96", data_out); end
  endtask

  task automatic test_async_reset();
    int bc, se, sse;
    bit tmo;
    start_xfer(1'b0, 8'hAA, 8'hCC);
    repeat (22) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (sclk !== 1'b0 || ss !== 1'b1) begin fails++; $display("[TB] FAIL abort_sclk_ss: got sclk=%b ss=%b expected 0 1", sclk, ss); end
    checks++; if (busy !== 1'b0 || mosi !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy_mosi: got busy=%b mosi=%b expected 0 0", busy, mosi); end
    checks++; if (data_out !== 8'h00) begin fails++; $display("[TB] FAIL abort_data_out: got %h expected 00", data_out); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data_out !== 8'h00 || busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_no_partial: got data=%h busy=%b expected 00 0", data_out, busy); end
    start_xfer(1'b0, 8'hAA, 8'hCC);
    measure(1'b0, -1, bc, se, sse, tmo);
    checks++; if (tmo !== 1'b0 || bc != 64 || se != 0) begin fails++; $display("[TB] FAIL abort_recover_timing: got len=%0d sclk_err=%0d expected 64 0", bc, se); end
    checks++; if (data_out !== 8'hCC || mosi_cap !== 8'hAA) begin fails++; $display("[TB] FAIL abort_recover_data: got rx=%h tx=%h expected cc aa", data_out, mosi_cap); end
  endtask

  task automatic test_fast_div();
    int bc, se, sse, r0;
    bit tmo;
    r0 = rise_cnt1;
    start_xfer(1'b1, 8'hA5, 8'h5A);
    measure(1'b1, -1, bc, se, sse, tmo);
    checks++; if (tmo !== 1'b0 || bc != 16) begin fails++; $display("[TB] FAIL fast_busy_len: got %0d expected 16", bc); end
    checks++; if (se != 0 || sse != 0) begin fails++; $display("[TB] FAIL fast_wave: got sclk_err=%0d ss_err=%0d expected 0 0", se, sse); end
    checks++; if (rise_cnt1 - r0 != 8) begin fails++; $display("[TB] FAIL fast_rise_count: got %0d expected 8", rise_cnt1 - r0); end
    checks++; if (mosi_cap1 !== 8'hA5) begin fails++; $display("[TB] FAIL fast_mosi: got %h expected a5", mosi_cap1); end
    checks++; if (data_out1 !== 8'h5A) begin fails++; $display("[TB] FAIL fast_data_out: got %h expected 5a", data_out1); end
  endtask

  // Scenarios run in sequence; each leaves the masters idle for the next.
  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_held_start();
    test_async_reset();
    test_fast_div();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mode_0.md
Name: mode_0

Overview:
SPI master implementing SPI Mode 0 (CPOL=0, CPHA=0) for single 8-bit full-duplex transfers.
- Sits between a local controller, which issues start with a byte, and one external SPI slave, reached over sclk/mosi/miso/ss.
- Shifts out data_in MSB-first while capturing miso into data_out.
- Reports activity on busy.

Parameters:
- CLK_DIV, default 4: system clocks per SCLK half-period. SCLK frequency = clk / (2*CLK_DIV). Legal values are integers ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  single-cycle transfer request, sampled only in IDLE.
- data_in  input  8  byte to transmit, captured on the accepted start.
- miso  input  1  serial data from slave.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  serial data to slave.
- ss  output  1  active-low slave select.
- data_out  output  8  last received byte.
- busy  output  1  high while a transfer is in progress.

Behaviour:
- Reset (rst=0, asynchronous) forces the following; all outputs are registered:
  - sclk=0, mosi=0, ss=1, busy=0, data_out=8'h00
  - state=IDLE; divider counter, bit counter and shift registers cleared.
- States are IDLE and XFER.
- IDLE:
  - sclk=0, ss=1, busy=0, mosi=0.
  - On a clk edge with start=1:
    - tx_shift<=data_in, mosi<=data_in[7]
    - ss<=0, busy<=1, divider<=0, edge count<=0
    - go to XFER.
  - So busy/ss change on the edge after start is sampled.
- XFER:
  - The divider counts 0..CLK_DIV-1. Each wrap is a half-period event; 16 events per byte, numbered k=1..16.
  - The first event occurs CLK_DIV clocks after entry.
  - Odd k (rising edge): sclk<=1; sample miso into rx_shift LSB (rx_shift <= {rx_shift[6:0], miso}).
  - Even k (falling edge, k<16): sclk<=0; shift tx, mosi<=next bit (MSB-first order).
  - k=16 (final falling edge), all in the same clk edge:
    - sclk<=0, data_out<=rx_shift (all 8 sampled bits), ss<=1, busy<=0, mosi<=0
    - return to IDLE.
- Mode 0 timing guarantees:
  - mosi is stable ≥CLK_DIV clocks before each rising sclk edge.
  - mosi changes only on falling edges or at start.
  - miso is sampled exactly at the rising edges.
- busy is high for exactly 16*CLK_DIV clk cycles (64 at default); ss low for the same window.
- start asserted while busy=1 is ignored, with no queueing. data_in changes during XFER have no effect.
- start held high continuously: a new transfer begins on the first clk edge after returning to IDLE, giving a minimum 1-cycle ss-high gap.
- data_out holds its value between transfers; it changes only at transfer completion or reset.
- Reset mid-transfer aborts immediately to reset values. data_out clears to 0; no partial byte is stored.
- Exactly 8 rising sclk edges per transfer; no extra edges at entry or exit.

Test Plan:
- Basic exchange: reset, then start with data_in=8'hAA; slave presents 8'hCC MSB-first (changing on falling sclk, first bit before first rise). Required: mosi at rising edges = 1,0,1,0,1,0,1,0; data_out=8'hCC when busy falls; ss low only while busy.
- Timing: CLK_DIV=4. Required: busy high exactly 64 clks; sclk period 8 clks; 8 rising edges; sclk=0 before and after the transfer; first rise 4 clks after busy rises.
- Ignore start while busy: pulse start with data_in=8'h55 mid-transfer of 8'hAA. Required: mosi still sends 8'hAA and busy ends at 64 clks; no second transfer follows.
- Back-to-back: transfer 8'h0F (slave 8'hF0), then 8'h81 (slave 8'h3C). Required: data_out=8'hF0 then 8'h3C; ss returns high between transfers.
- Async reset mid-transfer: drive rst=0 between clk edges after ~20 clks. Required: immediately sclk=0, ss=1, busy=0, mosi=0, data_out=0. After release, a new 8'hAA/8'hCC transfer completes correctly.
- CLK_DIV=1: transfer 8'hA5 with slave 8'h5A. Required: busy 16 clks, sclk toggles every clk, data_out=8'h5A.
